// File: rtl/mvau_decoupled.sv
// Matrix-vector unit with a separate weight stream and an internal activation buffer.
// The first row tile consumes live activations and stores them; later row tiles replay them.
module mvau_decoupled #(
    parameter int SIMD       = 2,
    parameter int PE         = 2,
    parameter int MatrixW    = 4,
    parameter int MatrixH    = 4,
    parameter int TSrcI      = 4,
    parameter int TW         = 4,
    parameter int TDstI      = 16,
    parameter bit SIGNED_ACT = 1'b1,
    parameter bit SIGNED_WGT = 1'b1,
    parameter int MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SIMD*TSrcI-1:0]   in,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic [PE*SIMD*TW-1:0]   wgt,
    input  logic                    wgt_v,
    output logic                    wgt_rdy,
    output logic [PE*TDstI-1:0]     out,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic                    out_last
);

    localparam int SF  = MatrixW / SIMD;
    localparam int NF  = MatrixH / PE;
    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SFW-1:0] SF_LAST = SFW'(SF - 1);
    localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SFW-1:0]          sf_cnt_q, sf_cnt_d;
    logic [NFW-1:0]          nf_cnt_q, nf_cnt_d;
    logic [PE*TDstI-1:0]     acc_q, acc_d;
    logic [PE*TDstI-1:0]     out_q, out_d;
    logic                    out_v_q, out_v_d;
    logic                    out_last_q, out_last_d;

    // Depth rounded up to a power of two so the counter always indexes in range.
    logic [SIMD*TSrcI-1:0]   act_buf [2**SFW];

    logic [SIMD*TSrcI-1:0]   act_s;
    logic                    stall_s;
    logic                    fire_s;
    logic [PE*TDstI-1:0]     sum_s;
    logic [PE*TDstI-1:0]     acc_next_s;

    function automatic logic [TDstI-1:0] lane_term(input logic [TSrcI-1:0] a,
                                                   input logic [TW-1:0]    w);
        logic [TDstI-1:0] a_ext;
        logic [TDstI-1:0] w_ext;
        logic             match;
        if (SIGNED_ACT) a_ext = TDstI'($signed(a));
        else            a_ext = TDstI'(a);
        if (SIGNED_WGT) w_ext = TDstI'($signed(w));
        else            w_ext = TDstI'(w);
        match = ~(a[0] ^ w[0]);
        if (MODE == 1) lane_term = TDstI'(match);
        else           lane_term = a_ext * w_ext;
    endfunction

    // Handshake steering: live activations in FILL, buffered ones in REPLAY.
    always_comb begin
        in_rdy  = 1'b0;
        wgt_rdy = 1'b0;
        fire_s  = 1'b0;
        act_s   = in;
        stall_s = out_v_q & ~out_rdy & (sf_cnt_q == SF_LAST);
        case (state_q)
            FILL: begin
                in_rdy  = wgt_v & ~stall_s;
                wgt_rdy = in_v & ~stall_s;
                fire_s  = in_v & wgt_v & ~stall_s;
                act_s   = in;
            end
            REPLAY: begin
                in_rdy  = 1'b0;
                wgt_rdy = ~stall_s;
                fire_s  = wgt_v & ~stall_s;
                act_s   = act_buf[sf_cnt_q];
            end
            default: begin
                in_rdy  = 1'b0;
                wgt_rdy = 1'b0;
                fire_s  = 1'b0;
                act_s   = in;
            end
        endcase
    end

    // Per-PE dot product of this beat, and the accumulator value it produces.
    always_comb begin
        sum_s      = {(PE*TDstI){1'b0}};
        acc_next_s = {(PE*TDstI){1'b0}};
        for (int p = 0; p < PE; p++) begin
            for (int s = 0; s < SIMD; s++) begin
                sum_s[p*TDstI +: TDstI] = sum_s[p*TDstI +: TDstI]
                    + lane_term(act_s[s*TSrcI +: TSrcI], wgt[(p*SIMD+s)*TW +: TW]);
            end
            if (sf_cnt_q == {SFW{1'b0}}) acc_next_s[p*TDstI +: TDstI] = sum_s[p*TDstI +: TDstI];
            else acc_next_s[p*TDstI +: TDstI] = acc_q[p*TDstI +: TDstI] + sum_s[p*TDstI +: TDstI];
        end
    end

    // Counter sequencing, accumulator update and output register load/drain.
    always_comb begin
        state_d    = state_q;
        sf_cnt_d   = sf_cnt_q;
        nf_cnt_d   = nf_cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        out_v_d    = out_v_q;
        out_last_d = out_last_q;
        if (out_v_q & out_rdy) begin
            out_v_d    = 1'b0;
            out_last_d = 1'b0;
        end else begin
            out_v_d    = out_v_q;
            out_last_d = out_last_q;
        end
        if (fire_s) begin
            acc_d = acc_next_s;
            if (sf_cnt_q == SF_LAST) begin
                sf_cnt_d   = {SFW{1'b0}};
                out_d      = acc_next_s;
                out_v_d    = 1'b1;
                out_last_d = (nf_cnt_q == NF_LAST);
                if (nf_cnt_q == NF_LAST) begin
                    nf_cnt_d = {NFW{1'b0}};
                    state_d  = FILL;
                end else begin
                    nf_cnt_d = nf_cnt_q + 1'b1;
                    state_d  = REPLAY;
                end
            end else begin
                sf_cnt_d = sf_cnt_q + 1'b1;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            sf_cnt_q   <= {SFW{1'b0}};
            nf_cnt_q   <= {NFW{1'b0}};
            acc_q      <= {(PE*TDstI){1'b0}};
            out_q      <= {(PE*TDstI){1'b0}};
            out_v_q    <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sf_cnt_q   <= sf_cnt_d;
            nf_cnt_q   <= nf_cnt_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            out_v_q    <= out_v_d;
            out_last_q <= out_last_d;
        end
    end

    // Activation buffer is written on FILL beats only and never reset.
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && fire_s) begin
            act_buf[sf_cnt_q] <= in;
        end
    end

    assign out      = out_q;
    assign out_v    = out_v_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_mvau_decoupled.sv
// Bench for mvau_decoupled: directed table vectors, backpressure, reset and random
// traffic against an arithmetic matrix-vector model, plus XNOR and wrap configurations.
module tb_mvau_decoupled;

    localparam int SF0 = 2;
    localparam int NF0 = 2;

    logic clk;
    logic rst_n;

    logic [7:0]  in0;
    logic        in_v0, in_rdy0;
    logic [15:0] wgt0;
    logic        wgt_v0, wgt_rdy0;
    logic [31:0] out0;
    logic        out_v0, out_rdy0, out_last0;

    logic [3:0]  in1;
    logic        in_v1, in_rdy1;
    logic [3:0]  wgt1;
    logic        wgt_v1, wgt_rdy1;
    logic [15:0] out1;
    logic        out_v1, out_rdy1, out_last1;

    logic [15:0] in2;
    logic        in_v2, in_rdy2;
    logic [15:0] wgt2;
    logic        wgt_v2, wgt_rdy2;
    logic [7:0]  out2;
    logic        out_v2, out_rdy2, out_last2;

    mvau_decoupled dut0 (
        .clk(clk), .rst_n(rst_n),
        .in(in0), .in_v(in_v0), .in_rdy(in_rdy0),
        .wgt(wgt0), .wgt_v(wgt_v0), .wgt_rdy(wgt_rdy0),
        .out(out0), .out_v(out_v0), .out_rdy(out_rdy0), .out_last(out_last0)
    );

    mvau_decoupled #(
        .SIMD(4), .PE(1), .MatrixW(8), .MatrixH(1), .TSrcI(1), .TW(1), .TDstI(16), .MODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in(in1), .in_v(in_v1), .in_rdy(in_rdy1),
        .wgt(wgt1), .wgt_v(wgt_v1), .wgt_rdy(wgt_rdy1),
        .out(out1), .out_v(out_v1), .out_rdy(out_rdy1), .out_last(out_last1)
    );

    mvau_decoupled #(
        .SIMD(2), .PE(1), .MatrixW(2), .MatrixH(1), .TSrcI(8), .TW(8), .TDstI(8),
        .SIGNED_ACT(1'b1), .SIGNED_WGT(1'b1), .MODE(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in(in2), .in_v(in_v2), .in_rdy(in_rdy2),
        .wgt(wgt2), .wgt_v(wgt_v2), .wgt_rdy(wgt_rdy2),
        .out(out2), .out_v(out_v2), .out_rdy(out_rdy2), .out_last(out_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;   // a[c] at [4c +: 4]
        logic [63:0] w;   // w[r][c] at [(4r+c)*4 +: 4]
        logic [31:0] e0;  // rows 1:0
        logic [31:0] e1;  // rows 3:2
    } vec_t;

    vec_t        tbl [4];
    logic [7:0]  act_q [$];
    logic [15:0] wgt_q [$];
    logic [32:0] exp_q [$];
    int          close_q [$];
    int          wcount;
    int          checks;
    int          passes;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    endtask

    function automatic logic [32:0] model_tile(input logic [15:0] a, input logic [63:0] w,
                                               input int nf);
        logic [31:0] t;
        int acc, av, wv;
        t = 32'h0;
        for (int p = 0; p < 2; p++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) begin
                av = $signed(a[c*4 +: 4]);
                wv = $signed(w[((nf*2+p)*4 + c)*4 +: 4]);
                acc += av * wv;
            end
            t[p*16 +: 16] = acc[15:0];
        end
        return {(nf == NF0-1), t};
    endfunction

    task automatic push_vec(input logic [15:0] a, input logic [63:0] w);
        logic [15:0] tile;
        for (int sf = 0; sf < SF0; sf++) act_q.push_back(a[sf*8 +: 8]);
        for (int nf = 0; nf < NF0; nf++) begin
            for (int sf = 0; sf < SF0; sf++) begin
                tile = 16'h0;
                for (int p = 0; p < 2; p++)
                    for (int s = 0; s < 2; s++)
                        tile[(p*2+s)*4 +: 4] = w[((nf*2+p)*4 + sf*2+s)*4 +: 4];
                wgt_q.push_back(tile);
            end
        end
    endtask

    // omode: 0 ready always, 1 random, 2 low for 10 cycles after first out_v, 3 never
    task automatic run(input int prob, input int omode, input int stop_w, input int budget);
        int cyc, first_ov, wrun, viol, rviol, hold_viol, stall_acc, c0;
        logic prev_ov, prev_drain, prev_last, replay, stall_e, e_in_rdy, e_wgt_rdy;
        logic [31:0] prev_out;
        logic [32:0] e;
        bit done;
        cyc = 0; first_ov = -1; wrun = 0; viol = 0; rviol = 0; hold_viol = 0; stall_acc = 0;
        prev_ov = 1'b0; prev_drain = 1'b0; prev_last = 1'b0; prev_out = 32'h0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (act_q.size() > 0 && $urandom_range(99) < prob) begin
                in_v0 = 1'b1; in0 = act_q[0];
            end else begin
                in_v0 = 1'b0; in0 = 8'h00;
            end
            if (wgt_q.size() > 0 && $urandom_range(99) < prob) begin
                wgt_v0 = 1'b1; wgt0 = wgt_q[0];
            end else begin
                wgt_v0 = 1'b0; wgt0 = 16'h0000;
            end
            case (omode)
                0:       out_rdy0 = 1'b1;
                1:       out_rdy0 = 1'($urandom_range(1));
                2:       out_rdy0 = (first_ov >= 0) && (cyc >= first_ov + 10);
                default: out_rdy0 = 1'b0;
            endcase
            #4;
            replay    = (wcount % (SF0*NF0)) >= SF0;
            stall_e   = out_v0 && !out_rdy0 && ((wcount % SF0) == SF0-1);
            e_in_rdy  = !replay && wgt_v0 && !stall_e;
            e_wgt_rdy = replay ? !stall_e : (in_v0 && !stall_e);
            if (in_rdy0 !== e_in_rdy || wgt_rdy0 !== e_wgt_rdy) viol++;
            if (replay && in_rdy0) rviol++;
            if (prev_ov && !prev_drain &&
                !(out_v0 === 1'b1 && out0 === prev_out && out_last0 === prev_last)) hold_viol++;
            if (out_v0 && first_ov < 0) first_ov = cyc;
            if (out_v0 && (!prev_ov || prev_drain)) begin
                c0 = (close_q.size() > 0) ? close_q.pop_front() : -10;
                chk("out_latency", 64'(cyc - c0), 64'd1);
            end
            prev_drain = 1'b0;
            if (out_v0 && out_rdy0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
                chk("out_tile", {31'h0, out_last0, out0}, {31'h0, e});
                prev_drain = 1'b1;
            end
            if (in_v0 && in_rdy0) void'(act_q.pop_front());
            if (wgt_v0 && wgt_rdy0) begin
                if (out_v0 && !out_rdy0) stall_acc++;
                if ((wcount % SF0) == SF0-1) close_q.push_back(cyc);
                wcount++;
                wrun++;
                void'(wgt_q.pop_front());
            end
            prev_ov = out_v0; prev_out = out0; prev_last = out_last0;
            cyc++;
            if (stop_w > 0) done = (wrun >= stop_w);
            else done = (act_q.size() == 0 && wgt_q.size() == 0 && exp_q.size() == 0);
            if (!done && cyc >= budget) begin
                checks++;
                $display("FAIL run_timeout: got %0d cycles, required completion within %0d", cyc, budget);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_v0 = 1'b0; wgt_v0 = 1'b0;
        if (stop_w == 0) begin
            chk("ready_rules", 64'(viol), 64'd0);
            chk("in_rdy_in_replay", 64'(rviol), 64'd0);
            chk("output_hold", 64'(hold_viol), 64'd0);
            chk("all_tiles_emitted", 64'(close_q.size()), 64'd0);
        end
        if (omode == 2) chk("accept_during_stall", 64'(stall_acc > 0), 64'd1);
    endtask

    task automatic push_tbl(input int i);
        push_vec(tbl[i].a, tbl[i].w);
        exp_q.push_back({1'b0, tbl[i].e0});
        exp_q.push_back({1'b1, tbl[i].e1});
    endtask

    initial begin
        logic [15:0] ra;
        logic [63:0] rw;
        checks = 0; passes = 0; wcount = 0;
        tbl[0] = '{a: 16'h4321, w: 64'h0002_FFFF_0101_1111, e0: 32'h0004_000A, e1: 32'h0002_FFF6};
        tbl[1] = '{a: 16'hFFFF, w: 64'h7777_7777_7777_7777, e0: 32'hFFE4_FFE4, e1: 32'hFFE4_FFE4};
        tbl[2] = '{a: 16'h7777, w: 64'h8888_8888_8888_8888, e0: 32'hFF20_FF20, e1: 32'hFF20_FF20};
        tbl[3] = '{a: 16'h1078, w: 64'h000F_7000_4321_8888, e0: 32'h000A_0000, e1: 32'h0008_0007};

        rst_n = 1'b0;
        in0 = 8'h0;  in_v0 = 1'b0; wgt0 = 16'h0; wgt_v0 = 1'b0; out_rdy0 = 1'b1;
        in1 = 4'h0;  in_v1 = 1'b0; wgt1 = 4'h0;  wgt_v1 = 1'b0; out_rdy1 = 1'b1;
        in2 = 16'h0; in_v2 = 1'b0; wgt2 = 16'h0; wgt_v2 = 1'b0; out_rdy2 = 1'b1;
        #12;
        chk("reset_out_v", 64'(out_v0), 64'd0);
        chk("reset_out_last", 64'(out_last0), 64'd0);
        chk("reset_out", 64'(out0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            push_tbl(i);
            run(100, 0, 0, 200);
        end

        // First table vector again with the output held off for 10 cycles.
        push_tbl(0);
        run(100, 2, 0, 300);

        for (int v = 0; v < 20; v++) begin
            ra = 16'($urandom);
            rw = {32'($urandom), 32'($urandom)};
            push_vec(ra, rw);
            exp_q.push_back(model_tile(ra, rw, 0));
            exp_q.push_back(model_tile(ra, rw, 1));
        end
        run(50, 1, 0, 5000);

        // Asynchronous reset while the second row tile is in progress.
        push_tbl(0);
        run(100, 3, 3, 200);
        in_v0 = 1'b1; wgt_v0 = 1'b1;
        #1;
        chk("pre_reset_out_v", 64'(out_v0), 64'd1);
        chk("pre_reset_replay_in_rdy", 64'(in_rdy0), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_v", 64'(out_v0), 64'd0);
        chk("async_reset_out_last", 64'(out_last0), 64'd0);
        chk("async_reset_out", 64'(out0), 64'd0);
        chk("async_reset_fill_in_rdy", 64'(in_rdy0), 64'd1);
        in_v0 = 1'b0; wgt_v0 = 1'b0;
        act_q.delete(); wgt_q.delete(); exp_q.delete(); close_q.delete();
        wcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push_tbl(0);
        run(100, 0, 0, 200);

        // XNOR-popcount configuration: 0xF.0xF then 0x0.0xF.
        @(negedge clk);
        in1 = 4'hF; wgt1 = 4'hF; in_v1 = 1'b1; wgt_v1 = 1'b1;
        #1;
        chk("xnor_in_rdy", 64'(in_rdy1), 64'd1);
        @(negedge clk);
        in1 = 4'h0; wgt1 = 4'hF;
        #1;
        chk("xnor_wgt_rdy", 64'(wgt_rdy1), 64'd1);
        chk("xnor_no_early_out", 64'(out_v1), 64'd0);
        @(negedge clk);
        in_v1 = 1'b0; wgt_v1 = 1'b0;
        chk("xnor_out_v", 64'(out_v1), 64'd1);
        chk("xnor_out", 64'(out1), 64'd4);
        chk("xnor_out_last", 64'(out_last1), 64'd1);

        // Narrow accumulator: 127*1 + 1*1 wraps to 0x80.
        @(negedge clk);
        in2 = {8'd1, 8'd127}; wgt2 = {8'd1, 8'd1}; in_v2 = 1'b1; wgt_v2 = 1'b1;
        @(negedge clk);
        in_v2 = 1'b0; wgt_v2 = 1'b0;
        chk("wrap_out_v", 64'(out_v2), 64'd1);
        chk("wrap_out", 64'(out2), 64'h80);
        chk("wrap_out_last", 64'(out_last2), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
